rip_gshare_predictor: RTL and testbench

Parametrised gshare direction predictor for the RIP fetch stage. It replaces the fixed always-taken predictor. A pattern history table (PHT) of saturating counters is indexed by PC bits XOR a speculative global history register (GHR). The predictor is trained and repaired by branch resolution from execute. A reset-time sweep FSM initialises the PHT before predictions are served.

---
 rtl/rip_branch_pkg.sv | 24 ++
 rtl/rip_pht_ram.sv | 27 ++
 rtl/rip_gshare_predictor.sv | 90 +++++++++
 tb/tb_rip_gshare_predictor.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/rip_branch_pkg.sv
// rip_branch_pkg: shared types and helpers for the RIP gshare direction predictor
package rip_branch_pkg;

   typedef enum logic {INIT, RUN} state_t;

   function automatic logic [31:0] weak_taken(input int cbits);
      return 32'd1 << (cbits - 1);
   endfunction

   function automatic logic [31:0] counter_next(input logic [31:0] cnt, input logic taken, input int cbits);
      logic [31:0] top;
      top = (32'd1 << cbits) - 32'd1;
      return taken ? ((cnt == top) ? cnt : cnt + 32'd1) : ((cnt == 32'd0) ? cnt : cnt - 32'd1);
   endfunction

   // ghr arrives zero-extended; the index mask keeps only its low ibits bits
   function automatic logic [31:0] pht_index(input logic [31:0] pc, input logic [31:0] ghr, input int pc_lsb,
                                             input int ibits, input logic gshare);
      logic [31:0] mask;
      mask = (32'd1 << ibits) - 32'd1;
      return ((pc >> pc_lsb) ^ (gshare ? ghr : 32'd0)) & mask;
   endfunction

endpackage

// File: rtl/rip_pht_ram.sv
// rip_pht_ram: counter table with async read, and a write port that either loads weakly-taken or steps a counter
module rip_pht_ram
   import rip_branch_pkg::*;
#(
   parameter int AW = 10,
   parameter int CB = 2
) (
   input  logic          clk,
   input  logic [AW-1:0] i_raddr,
   output logic [CB-1:0] o_rdata,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic          i_init,
   input  logic          i_taken
);

   logic [CB-1:0] r_mem [2**AW];
   logic [CB-1:0] w_wdata;

   assign o_rdata = r_mem[i_raddr];
   assign w_wdata = i_init ? CB'(weak_taken(CB)) : CB'(counter_next(32'(r_mem[i_waddr]), i_taken, CB));

   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= w_wdata;
   end

endmodule

// File: rtl/rip_gshare_predictor.sv
// rip_gshare_predictor: gshare/bimodal direction predictor with speculative GHR, repair and reset-time PHT sweep
module rip_gshare_predictor
   import rip_branch_pkg::*;
#(
   parameter int PHT_INDEX_BITS       = 10,
   parameter int GLOBAL_HISTORY_DEPTH = 10,
   parameter int PC_LSB               = 2,
   parameter int COUNTER_BITS         = 2,
   parameter int USE_GSHARE           = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   output logic                            ready,
   input  logic                            pred_req,
   input  logic [31:0]                     pred_pc,
   output logic                            pred_valid,
   output logic                            pred_taken,
   output logic [GLOBAL_HISTORY_DEPTH-1:0] pred_ghr,
   input  logic                            upd_valid,
   input  logic [31:0]                     upd_pc,
   input  logic [GLOBAL_HISTORY_DEPTH-1:0] upd_ghr,
   input  logic                            upd_taken,
   input  logic                            upd_mispredict
);

   localparam int IB = PHT_INDEX_BITS;
   localparam int D  = GLOBAL_HISTORY_DEPTH;

   state_t                  r_state, w_state_nxt;
   logic [IB-1:0]           r_ptr, w_pidx, w_uidx, w_waddr;
   logic [D-1:0]            r_ghr, w_ghr_nxt, r_pred_ghr;
   logic                    r_pred_valid, r_pred_taken;
   logic                    w_run, w_bit, w_accept, w_repair, w_we;
   logic [COUNTER_BITS-1:0] w_pcnt;

   assign w_run    = r_state == RUN;
   assign w_accept = w_run && pred_req;
   assign w_repair = w_run && upd_valid && upd_mispredict;
   assign w_pidx   = IB'(pht_index(pred_pc, 32'(r_ghr), PC_LSB, IB, USE_GSHARE != 0));
   assign w_uidx   = IB'(pht_index(upd_pc, 32'(upd_ghr), PC_LSB, IB, USE_GSHARE != 0));
   assign w_bit    = 32'(w_pcnt) >= weak_taken(COUNTER_BITS);
   assign w_we     = !rst && (!w_run || upd_valid);
   assign w_waddr  = w_run ? w_uidx : r_ptr;

   rip_pht_ram #(.AW(IB), .CB(COUNTER_BITS)) u_pht (
      .clk     (clk),
      .i_raddr (w_pidx),
      .o_rdata (w_pcnt),
      .i_we    (w_we),
      .i_waddr (w_waddr),
      .i_init  (!w_run),
      .i_taken (upd_taken)
   );

   always_ff @(posedge clk) begin
      if (rst) r_state <= INIT;
      else     r_state <= w_state_nxt;
   end

   // repair from execute wins over the speculative shift of a same-cycle prediction
   always_comb begin
      w_state_nxt = (r_state == INIT && r_ptr == '1) ? RUN : r_state;
      w_ghr_nxt   = w_repair ? (upd_ghr << 1) | D'(upd_taken) :
                    w_accept ? (r_ghr << 1) | D'(w_bit) : r_ghr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr        <= '0;
         r_ghr        <= '0;
         r_pred_valid <= 1'b0;
         r_pred_taken <= 1'b0;
         r_pred_ghr   <= '0;
      end else begin
         r_ptr        <= w_run ? r_ptr : r_ptr + IB'(1);
         r_ghr        <= w_ghr_nxt;
         r_pred_valid <= w_accept;
         if (w_accept) begin
            r_pred_taken <= w_bit;
            r_pred_ghr   <= r_ghr;
         end
      end
   end

   assign ready      = w_run;
   assign pred_valid = r_pred_valid;
   assign pred_taken = r_pred_taken;
   assign pred_ghr   = r_pred_ghr;

endmodule

// File: tb/tb_rip_gshare_predictor.sv
// tb_rip_gshare_predictor: directed stimulus, per-cycle model compare on the default build, literal checks on small builds
module tb_rip_gshare_predictor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        ready, pred_req, pred_valid, pred_taken, upd_valid, upd_taken, upd_mispredict;
   logic [31:0] pred_pc, upd_pc;
   logic [9:0]  pred_ghr, upd_ghr;

   logic        s_pred_req, s_upd_valid, s_upd_taken, s_upd_mispredict;
   logic [31:0] s_pred_pc, s_upd_pc;
   logic [3:0]  s_upd_ghr;
   logic        b_ready, b_pv, b_pt, g_ready, g_pv, g_pt;
   logic [3:0]  b_pg, g_pg;

   rip_gshare_predictor dut (
      .clk(clk), .rst(rst), .ready(ready), .pred_req(pred_req), .pred_pc(pred_pc),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr), .upd_taken(upd_taken),
      .upd_mispredict(upd_mispredict)
   );

   rip_gshare_predictor #(.PHT_INDEX_BITS(6), .GLOBAL_HISTORY_DEPTH(4), .USE_GSHARE(0)) dut_bim (
      .clk(clk), .rst(rst), .ready(b_ready), .pred_req(s_pred_req), .pred_pc(s_pred_pc),
      .pred_valid(b_pv), .pred_taken(b_pt), .pred_ghr(b_pg),
      .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_ghr(s_upd_ghr), .upd_taken(s_upd_taken),
      .upd_mispredict(s_upd_mispredict)
   );

   rip_gshare_predictor #(.PHT_INDEX_BITS(6), .GLOBAL_HISTORY_DEPTH(4), .USE_GSHARE(1)) dut_gsh (
      .clk(clk), .rst(rst), .ready(g_ready), .pred_req(s_pred_req), .pred_pc(s_pred_pc),
      .pred_valid(g_pv), .pred_taken(g_pt), .pred_ghr(g_pg),
      .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_ghr(s_upd_ghr), .upd_taken(s_upd_taken),
      .upd_mispredict(s_upd_mispredict)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model of the default build: counters as ints, history as an int modulo 1024
   int m_pht [1024];
   int m_cnt = 0;
   int m_ghr = 0;
   int m_pg = 0;
   bit m_pv = 0, m_pt = 0, m_on = 0;

   always @(posedge clk) begin
      int ip, iu, nb, ng;
      if (rst) begin
         m_on = 1; m_cnt = 0; m_ghr = 0; m_pv = 0; m_pt = 0; m_pg = 0;
      end else if (m_cnt < 1024) begin
         m_cnt++;
         m_pv = 0;
         if (m_cnt == 1024) foreach (m_pht[i]) m_pht[i] = 2;
      end else begin
         ip = int'(((pred_pc >> 2) ^ 32'(m_ghr)) & 32'h3FF);
         nb = (m_pht[ip] >= 2) ? 1 : 0;
         ng = m_ghr;
         m_pv = pred_req;
         if (pred_req) begin
            m_pt = (nb != 0);
            m_pg = m_ghr;
            ng = (m_ghr * 2 + nb) % 1024;
         end
         if (upd_valid) begin
            iu = int'(((upd_pc >> 2) ^ 32'(upd_ghr)) & 32'h3FF);
            if (upd_taken) m_pht[iu] = (m_pht[iu] == 3) ? 3 : m_pht[iu] + 1;
            else           m_pht[iu] = (m_pht[iu] == 0) ? 0 : m_pht[iu] - 1;
            if (upd_mispredict) ng = (int'(upd_ghr) * 2 + int'(upd_taken)) % 1024;
         end
         m_ghr = ng;
      end
   end

   always @(negedge clk) begin
      if (m_on) begin
         chk("ready", 32'(ready), 32'(m_cnt >= 1024));
         chk("pred_valid", 32'(pred_valid), 32'(m_pv));
         chk("pred_taken", 32'(pred_taken), 32'(m_pt));
         chk("pred_ghr", 32'(pred_ghr), 32'(m_pg));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic upd(input logic [31:0] pc, input logic [9:0] g, input logic t, input logic m);
      upd_valid = 1; upd_pc = pc; upd_ghr = g; upd_taken = t; upd_mispredict = m;
      step();
      upd_valid = 0; upd_mispredict = 0;
   endtask

   task automatic ghr0();
      upd(32'h400, 10'h0, 1'b0, 1'b1);
   endtask

   task automatic pred(input logic [31:0] pc);
      pred_req = 1; pred_pc = pc;
      step();
      pred_req = 0;
   endtask

   task automatic supd(input logic [31:0] pc, input logic [3:0] g, input logic t, input logic m);
      s_upd_valid = 1; s_upd_pc = pc; s_upd_ghr = g; s_upd_taken = t; s_upd_mispredict = m;
      step();
      s_upd_valid = 0; s_upd_mispredict = 0;
   endtask

   task automatic spred(input logic [31:0] pc);
      s_pred_req = 1; s_pred_pc = pc;
      step();
      s_pred_req = 0;
   endtask

   task automatic wait_ready(output int n, output int ns);
      n = 0;
      ns = -1;
      while (!ready && n < 3000) begin
         step();
         n++;
         if (ns < 0 && b_ready && g_ready) ns = n;
      end
   endtask

   int n, ns;

   initial begin
      pred_req = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0; upd_ghr = 0; upd_taken = 0; upd_mispredict = 0;
      s_pred_req = 0; s_pred_pc = 0; s_upd_valid = 0; s_upd_pc = 0; s_upd_ghr = 0; s_upd_taken = 0;
      s_upd_mispredict = 0;
      rst = 1;
      step(); step();
      chk("rst_ready", 32'(ready), 32'd0);
      chk("rst_pred_ghr", 32'(pred_ghr), 32'd0);
      rst = 0;
      pred_req = 1; pred_pc = 32'h0;
      wait_ready(n, ns);
      chk("sweep_len", 32'(n), 32'd1024);
      chk("small_sweep_len", 32'(ns), 32'd64);
      step();
      pred_req = 0;
      chk("first_valid", 32'(pred_valid), 32'd1);
      chk("first_taken", 32'(pred_taken), 32'd1);
      chk("first_ghr", 32'(pred_ghr), 32'd0);

      upd(32'h100, 10'h0, 1'b0, 1'b0);
      upd(32'h100, 10'h0, 1'b0, 1'b0);
      ghr0(); pred(32'h100);
      chk("trained_nt", 32'(pred_taken), 32'd0);
      upd(32'h100, 10'h0, 1'b1, 1'b0);
      ghr0(); pred(32'h100);
      chk("cnt1_nt", 32'(pred_taken), 32'd0);
      upd(32'h100, 10'h0, 1'b1, 1'b0);
      upd(32'h100, 10'h0, 1'b1, 1'b0);
      ghr0(); pred(32'h100);
      chk("cnt3_t", 32'(pred_taken), 32'd1);
      upd(32'h100, 10'h0, 1'b1, 1'b0);
      upd(32'h100, 10'h0, 1'b1, 1'b0);
      upd(32'h100, 10'h0, 1'b0, 1'b0);
      ghr0(); pred(32'h100);
      chk("sat_then_dec_t", 32'(pred_taken), 32'd1);
      upd(32'h100, 10'h0, 1'b0, 1'b0);
      ghr0(); pred(32'h100);
      chk("sat_then_dec2_nt", 32'(pred_taken), 32'd0);

      ghr0();
      pred_req = 1; pred_pc = 32'h0;
      step(); chk("spec_ghr0", 32'(pred_ghr), 32'h000);
      step(); chk("spec_ghr1", 32'(pred_ghr), 32'h001);
      step(); chk("spec_ghr3", 32'(pred_ghr), 32'h003);
      upd_valid = 1; upd_pc = 32'h400; upd_ghr = 10'h005; upd_taken = 0; upd_mispredict = 1;
      step(); chk("repair_old_ghr", 32'(pred_ghr), 32'h007);
      upd_valid = 0; upd_mispredict = 0;
      step(); chk("repair_new_ghr", 32'(pred_ghr), 32'h00A);
      pred_req = 0;

      rst = 1; step(); rst = 0;
      repeat (500) step();
      chk("mid_sweep_ready", 32'(ready), 32'd0);
      rst = 1; step(); rst = 0;
      chk("restart_ready", 32'(ready), 32'd0);
      wait_ready(n, ns);
      chk("resweep_len", 32'(n), 32'd1024);
      pred(32'h100);
      chk("resweep_weak", 32'(pred_taken), 32'd1);
      chk("resweep_ghr", 32'(pred_ghr), 32'd0);

      supd(32'h200, 4'h5, 1'b0, 1'b0);
      supd(32'h200, 4'hA, 1'b0, 1'b0);
      supd(32'h080, 4'h2, 1'b1, 1'b1);
      spred(32'h200);
      chk("bim_p1_v", 32'(b_pv), 32'd1);
      chk("bim_p1_t", 32'(b_pt), 32'd0); chk("bim_p1_g", 32'(b_pg), 32'h5);
      chk("gsh_p1_t", 32'(g_pt), 32'd0); chk("gsh_p1_g", 32'(g_pg), 32'h5);
      spred(32'h200);
      chk("bim_p2_t", 32'(b_pt), 32'd0); chk("bim_p2_g", 32'(b_pg), 32'hA);
      chk("gsh_p2_t", 32'(g_pt), 32'd0); chk("gsh_p2_g", 32'(g_pg), 32'hA);
      spred(32'h200);
      chk("bim_p3_t", 32'(b_pt), 32'd0); chk("bim_p3_g", 32'(b_pg), 32'h4);
      chk("gsh_p3_t", 32'(g_pt), 32'd1); chk("gsh_p3_g", 32'(g_pg), 32'h4);
      spred(32'h004);
      chk("bim_p4_t", 32'(b_pt), 32'd1); chk("bim_p4_g", 32'(b_pg), 32'h8);
      chk("gsh_p4_t", 32'(g_pt), 32'd1); chk("gsh_p4_g", 32'(g_pg), 32'h9);

      step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
